// File: rtl/core_pipe_mem_pkg.sv
// Shared definitions for the core pipeline memory stage: widths, LSU op
// bit positions, alignment trap causes, slot FSM states and the payload
// carried from execute to writeback.
package core_common;

    localparam int XLEN       = 64;
    localparam int XL         = XLEN - 1;
    localparam int MEM_ADDR_R = 31;
    localparam int MEM_STRB_R = 7;
    localparam int MEM_DATA_R = 63;
    localparam int REG_ADDR_R = 4;
    localparam int LSU_OP_R   = 6;
    localparam int CSR_OP_R   = 2;
    localparam int CFU_OP_R   = 5;
    localparam int WB_OP_R    = 1;

    // LSU op is a bit vector: direction, access size and sign extension.
    localparam int LSU_LOAD   = 0;
    localparam int LSU_STORE  = 1;
    localparam int LSU_BYTE   = 2;
    localparam int LSU_HALF   = 3;
    localparam int LSU_WORD   = 4;
    localparam int LSU_DOUBLE = 5;
    localparam int LSU_SIGNED = 6;

    localparam logic [REG_ADDR_R:0] TRAP_LDALIGN = 5'd4;
    localparam logic [REG_ADDR_R:0] TRAP_STALIGN = 5'd6;

    typedef enum logic [2:0] {
        MEM_IDLE  = 3'd0,
        MEM_HOLD  = 3'd1,
        MEM_REQ   = 3'd2,
        MEM_DONE  = 3'd3,
        MEM_DRAIN = 3'd4
    } mem_state_t;

    // Everything the writeback stage receives from this stage.
    typedef struct packed {
        logic [XL:0]         pc;
        logic [XL:0]         n_pc;
        logic [XL:0]         wdata;
        logic [31:0]         instr;
        logic [REG_ADDR_R:0] rd;
        logic [LSU_OP_R:0]   lsu_op;
        logic [CSR_OP_R:0]   csr_op;
        logic [11:0]         csr_addr;
        logic [CFU_OP_R:0]   cfu_op;
        logic [WB_OP_R:0]    wb_op;
        logic                trap;
    } stage_fields_t;

endpackage

// File: rtl/core_pipe_mem_align.sv
// core_mem_align: byte strobe generation, store data lane positioning and
// misaligned-access detection for one data-memory access.
// With CORE_MEM_MISALIGN_TRAP_EN defined a misaligned address is flagged;
// otherwise the low address bits are masked down to natural alignment and
// the flag is tied low.
module core_mem_align
    import core_common::*;
(
    input  logic [1:0]          size,
    input  logic [XL:0]         addr,
    input  logic [XL:0]         sdata,
    output logic [XL:0]         eff_addr,
    output logic [MEM_STRB_R:0] strb,
    output logic [MEM_DATA_R:0] wdata,
    output logic                misalign
);

    logic [2:0]          low_mask;
    logic [2:0]          offset;
    logic [MEM_STRB_R:0] base_strb;

    // Size decode, alignment handling and lane shift of strobe and data.
    always_comb begin
        low_mask  = 3'b000;
        base_strb = 8'h01;
        case (size)
            2'd1: begin
                low_mask  = 3'b001;
                base_strb = 8'h03;
            end
            2'd2: begin
                low_mask  = 3'b011;
                base_strb = 8'h0F;
            end
            2'd3: begin
                low_mask  = 3'b111;
                base_strb = 8'hFF;
            end
            default: begin
                low_mask  = 3'b000;
                base_strb = 8'h01;
            end
        endcase
`ifdef CORE_MEM_MISALIGN_TRAP_EN
        offset   = addr[2:0];
        misalign = |(addr[2:0] & low_mask);
        eff_addr = addr;
`else
        offset   = addr[2:0] & ~low_mask;
        misalign = 1'b0;
        eff_addr = {addr[XL:3], offset};
`endif
        strb  = base_strb << offset;
        wdata = sdata << {offset, 3'b000};
    end

endmodule

// File: rtl/core_pipe_mem.sv
// core_pipe_mem: memory stage between execute (s2) and writeback (s3).
// Holds one instruction in a slot, issues data-memory requests for loads
// and stores, and owns the s3 pipeline register.
// Optional feature macro: CORE_MEM_MISALIGN_TRAP_EN (misaligned-access trap).
module core_pipe_mem
    import core_common::*;
(
    input  logic                  g_clk,
    input  logic                  g_reset,
    input  logic                  flush,

    input  logic                  s2_valid,
    output logic                  s2_ready,
    input  logic [XL:0]           s2_pc,
    input  logic [XL:0]           s2_n_pc,
    input  logic [XL:0]           s2_wdata,
    input  logic [XL:0]           s2_addr,
    input  logic [XL:0]           s2_sdata,
    input  logic [31:0]           s2_instr,
    input  logic [REG_ADDR_R:0]   s2_rd,
    input  logic [LSU_OP_R:0]     s2_lsu_op,
    input  logic [CSR_OP_R:0]     s2_csr_op,
    input  logic [11:0]           s2_csr_addr,
    input  logic [CFU_OP_R:0]     s2_cfu_op,
    input  logic [WB_OP_R:0]      s2_wb_op,
    input  logic                  s2_trap,

    output logic                  s3_valid,
    input  logic                  s3_ready,
    output logic                  s3_full,
    output logic [XL:0]           s3_pc,
    output logic [XL:0]           s3_n_pc,
    output logic [XL:0]           s3_wdata,
    output logic [31:0]           s3_instr,
    output logic [REG_ADDR_R:0]   s3_rd,
    output logic [LSU_OP_R:0]     s3_lsu_op,
    output logic [CSR_OP_R:0]     s3_csr_op,
    output logic [11:0]           s3_csr_addr,
    output logic [CFU_OP_R:0]     s3_cfu_op,
    output logic [WB_OP_R:0]      s3_wb_op,
    output logic                  s3_trap,

    output logic                  dmem_req,
    input  logic                  dmem_gnt,
    output logic [MEM_ADDR_R:0]   dmem_addr,
    output logic                  dmem_wen,
    output logic [MEM_STRB_R:0]   dmem_strb,
    output logic [MEM_DATA_R:0]   dmem_wdata
);

    mem_state_t          state_q, state_d;
    stage_fields_t       slot_q, slot_d, slot_in;
    stage_fields_t       s3_q, s3_d;
    logic                s3_full_q, s3_full_d;
    logic [MEM_ADDR_R:0] dmem_addr_q, dmem_addr_d;
    logic [MEM_STRB_R:0] dmem_strb_q, dmem_strb_d;
    logic [MEM_DATA_R:0] dmem_wdata_q, dmem_wdata_d;
    logic                dmem_wen_q, dmem_wen_d;

    logic [1:0]          acc_size;
    logic [XL:0]         al_eff_addr;
    logic [MEM_STRB_R:0] al_strb;
    logic [MEM_DATA_R:0] al_wdata;
    logic                al_misalign;

    logic                is_mem;
    logic                is_store;
    logic                misaligned;
    logic                start_req;
    logic                completes;
    logic                capture;

    // Access size from the LSU op bits, largest size wins.
    always_comb begin
        acc_size = 2'd0;
        if (s2_lsu_op[LSU_DOUBLE]) begin
            acc_size = 2'd3;
        end else if (s2_lsu_op[LSU_WORD]) begin
            acc_size = 2'd2;
        end else if (s2_lsu_op[LSU_HALF]) begin
            acc_size = 2'd1;
        end
    end

    core_mem_align u_align (
        .size     (acc_size),
        .addr     (s2_addr),
        .sdata    (s2_sdata),
        .eff_addr (al_eff_addr),
        .strb     (al_strb),
        .wdata    (al_wdata),
        .misalign (al_misalign)
    );

    // Decode the incoming instruction into the slot payload; LSU ops carry
    // their effective address as result, misaligned ones carry the cause.
    always_comb begin
        is_mem     = s2_lsu_op[LSU_LOAD] | s2_lsu_op[LSU_STORE];
        is_store   = s2_lsu_op[LSU_STORE];
        misaligned = is_mem && al_misalign;
        start_req  = is_mem && !s2_trap && !misaligned;

        slot_in          = '0;
        slot_in.pc       = s2_pc;
        slot_in.n_pc     = s2_n_pc;
        slot_in.wdata    = is_mem ? al_eff_addr : s2_wdata;
        slot_in.instr    = s2_instr;
        slot_in.rd       = misaligned ? (is_store ? TRAP_STALIGN : TRAP_LDALIGN) : s2_rd;
        slot_in.lsu_op   = s2_lsu_op;
        slot_in.csr_op   = s2_csr_op;
        slot_in.csr_addr = s2_csr_addr;
        slot_in.cfu_op   = s2_cfu_op;
        slot_in.wb_op    = s2_wb_op;
        slot_in.trap     = s2_trap | misaligned;
    end

    // Slot FSM next state and handshakes; flush overrides everything and a
    // flushed outstanding request is drained until memory grants it.
    always_comb begin
        completes = (state_q == MEM_HOLD) || (state_q == MEM_DONE) ||
                    ((state_q == MEM_REQ) && dmem_gnt);
        s3_valid  = completes && !flush;
        s2_ready  = !flush && ((state_q == MEM_IDLE) || (completes && s3_ready));
        capture   = s2_valid && s2_ready;
        dmem_req  = (state_q == MEM_REQ) || (state_q == MEM_DRAIN);

        state_d = state_q;
        case (state_q)
            MEM_HOLD, MEM_DONE: begin
                if (s3_ready) begin
                    state_d = MEM_IDLE;
                end
            end
            MEM_REQ: begin
                if (dmem_gnt) begin
                    state_d = s3_ready ? MEM_IDLE : MEM_DONE;
                end
            end
            MEM_DRAIN: begin
                if (dmem_gnt) begin
                    state_d = MEM_IDLE;
                end
            end
            default: state_d = state_q;
        endcase

        if (flush) begin
            if (((state_q == MEM_REQ) || (state_q == MEM_DRAIN)) && !dmem_gnt) begin
                state_d = MEM_DRAIN;
            end else begin
                state_d = MEM_IDLE;
            end
        end else if (capture) begin
            state_d = start_req ? MEM_REQ : MEM_HOLD;
        end
    end

    // Slot, request and s3 register next values; request fields only change
    // on capture so they stay stable while waiting for grant.
    always_comb begin
        slot_d       = slot_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_strb_d  = dmem_strb_q;
        dmem_wdata_d = dmem_wdata_q;
        dmem_wen_d   = dmem_wen_q;
        if (capture) begin
            slot_d       = slot_in;
            dmem_addr_d  = {al_eff_addr[MEM_ADDR_R:3], 3'b000};
            dmem_strb_d  = al_strb;
            dmem_wdata_d = al_wdata;
            dmem_wen_d   = is_store;
        end

        s3_d = s3_q;
        if (s3_valid && s3_ready) begin
            s3_d = slot_q;
        end

        if (s3_ready) begin
            s3_full_d = s3_valid;
        end else if (flush) begin
            s3_full_d = 1'b0;
        end else begin
            s3_full_d = s3_full_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q      <= MEM_IDLE;
            slot_q       <= '0;
            s3_q         <= '0;
            s3_full_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_strb_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_wen_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            s3_q         <= s3_d;
            s3_full_q    <= s3_full_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_strb_q  <= dmem_strb_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_wen_q   <= dmem_wen_d;
        end
    end

    assign s3_full     = s3_full_q;
    assign s3_pc       = s3_q.pc;
    assign s3_n_pc     = s3_q.n_pc;
    assign s3_wdata    = s3_q.wdata;
    assign s3_instr    = s3_q.instr;
    assign s3_rd       = s3_q.rd;
    assign s3_lsu_op   = s3_q.lsu_op;
    assign s3_csr_op   = s3_q.csr_op;
    assign s3_csr_addr = s3_q.csr_addr;
    assign s3_cfu_op   = s3_q.cfu_op;
    assign s3_wb_op    = s3_q.wb_op;
    assign s3_trap     = s3_q.trap;

    assign dmem_addr   = dmem_addr_q;
    assign dmem_wen    = dmem_wen_q;
    assign dmem_strb   = dmem_strb_q;
    assign dmem_wdata  = dmem_wdata_q;

endmodule

// File: tb/tb_core_pipe_mem.sv
// Directed testbench for core_pipe_mem with hand-computed expectations.
// Builds with or without CORE_MEM_MISALIGN_TRAP_EN.
module tb_core_pipe_mem;
    import core_common::*;

    localparam logic [LSU_OP_R:0] OP_ADD = 7'b0000000;
    localparam logic [LSU_OP_R:0] OP_LW  = 7'b0010001;
    localparam logic [LSU_OP_R:0] OP_SB  = 7'b0000110;
    localparam logic [LSU_OP_R:0] OP_LD  = 7'b0100001;

    logic                g_clk = 1'b0;
    logic                g_reset;
    logic                flush;
    logic                s2_valid;
    logic                s2_ready;
    logic [XL:0]         s2_pc, s2_n_pc, s2_wdata, s2_addr, s2_sdata;
    logic [31:0]         s2_instr;
    logic [REG_ADDR_R:0] s2_rd;
    logic [LSU_OP_R:0]   s2_lsu_op;
    logic [CSR_OP_R:0]   s2_csr_op;
    logic [11:0]         s2_csr_addr;
    logic [CFU_OP_R:0]   s2_cfu_op;
    logic [WB_OP_R:0]    s2_wb_op;
    logic                s2_trap;
    logic                s3_valid, s3_ready, s3_full;
    logic [XL:0]         s3_pc, s3_n_pc, s3_wdata;
    logic [31:0]         s3_instr;
    logic [REG_ADDR_R:0] s3_rd;
    logic [LSU_OP_R:0]   s3_lsu_op;
    logic [CSR_OP_R:0]   s3_csr_op;
    logic [11:0]         s3_csr_addr;
    logic [CFU_OP_R:0]   s3_cfu_op;
    logic [WB_OP_R:0]    s3_wb_op;
    logic                s3_trap;
    logic                dmem_req, dmem_gnt, dmem_wen;
    logic [MEM_ADDR_R:0] dmem_addr;
    logic [MEM_STRB_R:0] dmem_strb;
    logic [MEM_DATA_R:0] dmem_wdata;

    int checks = 0;
    int errors = 0;

    always #5 g_clk = ~g_clk;

    core_pipe_mem dut (
        .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
        .s2_valid(s2_valid), .s2_ready(s2_ready),
        .s2_pc(s2_pc), .s2_n_pc(s2_n_pc), .s2_wdata(s2_wdata),
        .s2_addr(s2_addr), .s2_sdata(s2_sdata), .s2_instr(s2_instr),
        .s2_rd(s2_rd), .s2_lsu_op(s2_lsu_op), .s2_csr_op(s2_csr_op),
        .s2_csr_addr(s2_csr_addr), .s2_cfu_op(s2_cfu_op), .s2_wb_op(s2_wb_op),
        .s2_trap(s2_trap),
        .s3_valid(s3_valid), .s3_ready(s3_ready), .s3_full(s3_full),
        .s3_pc(s3_pc), .s3_n_pc(s3_n_pc), .s3_wdata(s3_wdata),
        .s3_instr(s3_instr), .s3_rd(s3_rd), .s3_lsu_op(s3_lsu_op),
        .s3_csr_op(s3_csr_op), .s3_csr_addr(s3_csr_addr), .s3_cfu_op(s3_cfu_op),
        .s3_wb_op(s3_wb_op), .s3_trap(s3_trap),
        .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_addr(dmem_addr),
        .dmem_wen(dmem_wen), .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata)
    );

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one instruction (or a bubble) on the execute interface.
    task automatic applyStimulus(input logic valid, input logic [LSU_OP_R:0] op,
                                 input logic [XL:0] addr, input logic [XL:0] sdata,
                                 input logic [XL:0] wdata, input logic [REG_ADDR_R:0] rd);
        s2_valid    = valid;
        s2_lsu_op   = op;
        s2_addr     = addr;
        s2_sdata    = sdata;
        s2_wdata    = wdata;
        s2_rd       = rd;
        s2_pc       = 64'h100;
        s2_n_pc     = 64'h104;
        s2_instr    = 32'h13;
        s2_csr_op   = '0;
        s2_csr_addr = '0;
        s2_cfu_op   = '0;
        s2_wb_op    = 2'b01;
        s2_trap     = 1'b0;
    endtask

    // Advance to just after the next rising edge.
    task automatic stepCycle();
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        g_reset = 1'b1; flush = 1'b0; s3_ready = 1'b1; dmem_gnt = 1'b0;
        applyStimulus(1'b0, OP_ADD, '0, '0, '0, '0);
        stepCycle(); stepCycle();
        #1;
        checkOutput("rst_s3_full", s3_full, 0);
        checkOutput("rst_s3_valid", s3_valid, 0);
        checkOutput("rst_dmem_req", dmem_req, 0);
        checkOutput("rst_s2_ready", s2_ready, 1);
        checkOutput("rst_s3_wdata", s3_wdata, 0);
        checkOutput("rst_s3_rd", s3_rd, 0);
        checkOutput("rst_dmem_strb", dmem_strb, 0);
        checkOutput("rst_dmem_wen", dmem_wen, 0);
        g_reset = 1'b0;

        // ADD followed by LW at 0x1004 with immediate grant
        applyStimulus(1'b1, OP_ADD, '0, '0, 64'h55, 5'd3); dmem_gnt = 1'b1; #1;
        checkOutput("add_s2_ready", s2_ready, 1);
        stepCycle();
        applyStimulus(1'b1, OP_LW, 64'h1004, '0, 64'h99, 5'd5); #1;
        checkOutput("add_s3_valid", s3_valid, 1);
        checkOutput("lw_s2_ready", s2_ready, 1);
        checkOutput("add_no_req", dmem_req, 0);
        stepCycle();
        applyStimulus(1'b0, OP_ADD, '0, '0, '0, '0); #1;
        checkOutput("add_s3_full", s3_full, 1);
        checkOutput("add_s3_wdata", s3_wdata, 64'h55);
        checkOutput("add_s3_rd", s3_rd, 3);
        checkOutput("lw_req", dmem_req, 1);
        checkOutput("lw_addr", dmem_addr, 64'h1000);
        checkOutput("lw_strb", dmem_strb, 8'hF0);
        checkOutput("lw_wen", dmem_wen, 0);
        checkOutput("lw_s3_valid", s3_valid, 1);
        stepCycle(); #1;
        checkOutput("lw_s3_wdata", s3_wdata, 64'h1004);
        checkOutput("lw_s3_rd", s3_rd, 5);
        checkOutput("lw_s3_lsu_op", s3_lsu_op, OP_LW);
        checkOutput("lw_req_drop", dmem_req, 0);

        // SB of 0xAB at 0x2003
        stepCycle();
        applyStimulus(1'b1, OP_SB, 64'h2003, 64'h11223344556677AB, '0, 5'd9); #1;
        stepCycle();
        applyStimulus(1'b0, OP_ADD, '0, '0, '0, '0); #1;
        checkOutput("sb_req", dmem_req, 1);
        checkOutput("sb_strb", dmem_strb, 8'h08);
        checkOutput("sb_lane", dmem_wdata[31:24], 8'hAB);
        checkOutput("sb_wdata", dmem_wdata, 64'h44556677AB000000);
        checkOutput("sb_wen", dmem_wen, 1);
        checkOutput("sb_addr", dmem_addr, 64'h2000);
        stepCycle(); #1;
        checkOutput("sb_s3_wdata", s3_wdata, 64'h2003);
        checkOutput("sb_s3_lsu_op", s3_lsu_op, OP_SB);

        // LD at misaligned 0x3004
        stepCycle();
        applyStimulus(1'b1, OP_LD, 64'h3004, '0, '0, 5'd7); #1;
        stepCycle();
        applyStimulus(1'b0, OP_ADD, '0, '0, '0, '0); #1;
`ifdef CORE_MEM_MISALIGN_TRAP_EN
        checkOutput("ld_no_req", dmem_req, 0);
        checkOutput("ld_s3_valid", s3_valid, 1);
        stepCycle(); #1;
        checkOutput("ld_s3_trap", s3_trap, 1);
        checkOutput("ld_s3_rd", s3_rd, 4);
`else
        checkOutput("ld_req", dmem_req, 1);
        checkOutput("ld_addr", dmem_addr, 64'h3000);
        checkOutput("ld_strb", dmem_strb, 8'hFF);
        stepCycle(); #1;
        checkOutput("ld_s3_trap", s3_trap, 0);
        checkOutput("ld_s3_rd", s3_rd, 7);
`endif

        // LW at 0x4008 with grant withheld three cycles, ADD waiting behind it
        stepCycle();
        dmem_gnt = 1'b0;
        applyStimulus(1'b1, OP_LW, 64'h4008, '0, '0, 5'd10); #1;
        stepCycle();
        applyStimulus(1'b1, OP_ADD, '0, '0, 64'h77, 5'd11);
        for (int i = 0; i < 4; i++) begin
            dmem_gnt = (i == 3); #1;
            checkOutput($sformatf("wait_req_%0d", i), dmem_req, 1);
            checkOutput($sformatf("wait_addr_%0d", i), dmem_addr, 64'h4008);
            checkOutput($sformatf("wait_s2_ready_%0d", i), s2_ready, (i == 3) ? 1 : 0);
            checkOutput($sformatf("wait_s3_valid_%0d", i), s3_valid, (i == 3) ? 1 : 0);
            stepCycle();
        end
        applyStimulus(1'b0, OP_ADD, '0, '0, '0, '0); #1;
        checkOutput("wait_s3_wdata", s3_wdata, 64'h4008);
        checkOutput("wait_s3_rd", s3_rd, 10);
        checkOutput("b2b_add_valid", s3_valid, 1);
        stepCycle(); #1;
        checkOutput("b2b_add_wdata", s3_wdata, 64'h77);

        // Flush while a request is outstanding, grant two cycles later
        dmem_gnt = 1'b0; s3_ready = 1'b0;
        applyStimulus(1'b1, OP_LW, 64'h5000, '0, '0, 5'd12); #1;
        stepCycle();
        applyStimulus(1'b0, OP_ADD, '0, '0, '0, '0); flush = 1'b1; #1;
        checkOutput("fl_pre_full", s3_full, 1);
        checkOutput("fl_s3_valid", s3_valid, 0);
        checkOutput("fl_req", dmem_req, 1);
        stepCycle();
        flush = 1'b0; s3_ready = 1'b1; #1;
        checkOutput("fl_state", dut.state_q, MEM_DRAIN);
        checkOutput("fl_s3_full", s3_full, 0);
        checkOutput("fl_drain_req", dmem_req, 1);
        checkOutput("fl_drain_ready", s2_ready, 0);
        stepCycle();
        dmem_gnt = 1'b1; #1;
        checkOutput("fl_gnt_req", dmem_req, 1);
        checkOutput("fl_gnt_ready", s2_ready, 0);
        checkOutput("fl_gnt_valid", s3_valid, 0);
        stepCycle(); #1;
        checkOutput("fl_end_ready", s2_ready, 1);
        checkOutput("fl_end_req", dmem_req, 0);
        checkOutput("fl_no_load", s3_wdata, 64'h77);

        // Granted LW parked in DONE while writeback is not ready
        stepCycle();
        applyStimulus(1'b1, OP_LW, 64'h6000, '0, '0, 5'd13); #1;
        stepCycle();
        applyStimulus(1'b0, OP_ADD, '0, '0, '0, '0); s3_ready = 1'b0; #1;
        checkOutput("done_gnt_valid", s3_valid, 1);
        checkOutput("done_gnt_ready", s2_ready, 0);
        stepCycle();
        dmem_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checkOutput($sformatf("done_state_%0d", i), dut.state_q, MEM_DONE);
            checkOutput($sformatf("done_req_%0d", i), dmem_req, 0);
            checkOutput($sformatf("done_s2_ready_%0d", i), s2_ready, 0);
            checkOutput($sformatf("done_full_%0d", i), s3_full, 0);
            stepCycle();
        end
        s3_ready = 1'b1; #1;
        checkOutput("done_rel_valid", s3_valid, 1);
        checkOutput("done_rel_ready", s2_ready, 1);
        stepCycle(); #1;
        checkOutput("done_s3_full", s3_full, 1);
        checkOutput("done_s3_wdata", s3_wdata, 64'h6000);
        checkOutput("done_once_valid", s3_valid, 0);
        stepCycle(); #1;
        checkOutput("done_once_full", s3_full, 0);

        // Flush in the same cycle as an incoming instruction drops it
        applyStimulus(1'b1, OP_ADD, '0, '0, 64'h88, 5'd14); flush = 1'b1; #1;
        checkOutput("flin_s2_ready", s2_ready, 0);
        stepCycle();
        applyStimulus(1'b0, OP_ADD, '0, '0, '0, '0); flush = 1'b0; #1;
        checkOutput("flin_state", dut.state_q, MEM_IDLE);
        checkOutput("flin_s3_valid", s3_valid, 0);
        stepCycle(); #1;
        checkOutput("flin_s3_wdata", s3_wdata, 64'h6000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
